// File: rtl/mcycle_muldiv_if.sv
// Start/Busy handshake bundle between the Execute stage and the multi-cycle mul/div unit.
interface mcycle_muldiv_if #(
  parameter int unsigned WIDTH = 32
);
  logic             Start;
  logic [1:0]       MCycleOp;
  logic [WIDTH-1:0] Operand1;
  logic [WIDTH-1:0] Operand2;
  logic [WIDTH-1:0] Result;
  logic [WIDTH-1:0] ResultHi;
  logic             Busy;
  logic             Done;
  logic             DivByZero;

  modport master (
    output Start, MCycleOp, Operand1, Operand2,
    input  Result, ResultHi, Busy, Done, DivByZero
  );

  modport slave (
    input  Start, MCycleOp, Operand1, Operand2,
    output Result, ResultHi, Busy, Done, DivByZero
  );
endinterface

// File: rtl/mcycle_muldiv.sv
// WIDTH-generic multi-cycle signed/unsigned multiply and restoring divide.
// Optional macro MCYCLE_EARLY_OUT_EN: multiply stops once the remaining multiplier bits are zero.
module mcycle_muldiv #(
  parameter int unsigned WIDTH = 32
) (
  input logic           CLK,
  input logic           Reset,
  mcycle_muldiv_if.slave bus
);
  localparam int unsigned W2 = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_FIXUP, S_DONE} state_e;

  state_e           state_q, state_d;
  logic             is_div_q, is_div_d;
  logic             neg_lo_q, neg_lo_d;
  logic             neg_hi_q, neg_hi_d;
  logic             dz_q, dz_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] op1_q, op1_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] res_hi_q, res_hi_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic [W2-1:0]    mcand_q, mcand_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             a_neg, b_neg, last_iter;
  logic [WIDTH-1:0] mag1, mag2, q_fix, r_fix;
  logic [WIDTH:0]   diff;
  logic [W2-1:0]    prod_fix;

  // Operand magnitudes and sign-corrected results
  always_comb begin
    a_neg    = bus.MCycleOp[0] & bus.Operand1[WIDTH-1];
    b_neg    = bus.MCycleOp[0] & bus.Operand2[WIDTH-1];
    mag1     = a_neg ? -bus.Operand1 : bus.Operand1;
    mag2     = b_neg ? -bus.Operand2 : bus.Operand2;
    diff     = acc_q[W2-1:WIDTH-1] - {1'b0, mcand_q[WIDTH-1:0]};
    prod_fix = neg_lo_q ? -acc_q : acc_q;
    q_fix    = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    r_fix    = neg_hi_q ? -acc_q[W2-1:WIDTH] : acc_q[W2-1:WIDTH];
    last_iter = (cnt_q == CW'(WIDTH - 1));
`ifdef MCYCLE_EARLY_OUT_EN
    if (!is_div_q && (b_q[WIDTH-1:1] == '0)) last_iter = 1'b1;
`endif
  end

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    dz_d     = dz_q;
    dbz_d    = dbz_q;
    op1_d    = op1_q;
    b_d      = b_q;
    res_d    = res_q;
    res_hi_d = res_hi_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.Start) begin
          is_div_d = bus.MCycleOp[1];
          neg_lo_d = a_neg ^ b_neg;
          neg_hi_d = a_neg;
          dz_d     = bus.MCycleOp[1] && (bus.Operand2 == '0);
          op1_d    = bus.Operand1;
          b_d      = mag2;
          cnt_d    = '0;
          if (bus.MCycleOp[1]) begin
            acc_d   = {{WIDTH{1'b0}}, mag1};
            mcand_d = {{WIDTH{1'b0}}, mag2};
          end else begin
            acc_d   = '0;
            mcand_d = {{WIDTH{1'b0}}, mag1};
          end
          state_d = S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        cnt_d = cnt_q + CW'(1);
        if (is_div_q) begin
          // Trial subtract of the shifted partial remainder; keep it only if non-negative
          if (!diff[WIDTH]) acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          else              acc_d = {acc_q[W2-2:0], 1'b0};
        end else begin
          if (b_q[0]) acc_d = acc_q + mcand_q;
          mcand_d = mcand_q << 1;
          b_d     = b_q >> 1;
        end
        if (last_iter) state_d = S_FIXUP;
      end
      S_FIXUP: begin
        dbz_d = dz_q;
        if (dz_q) begin
          res_d    = '1;
          res_hi_d = op1_q;
        end else if (is_div_q) begin
          res_d    = q_fix;
          res_hi_d = r_fix;
        end else begin
          {res_hi_d, res_d} = prod_fix;
        end
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      dz_q     <= 1'b0;
      dbz_q    <= 1'b0;
      op1_q    <= '0;
      b_q      <= '0;
      res_q    <= '0;
      res_hi_q <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      cnt_q    <= '0;
    end else begin
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      dz_q     <= dz_d;
      dbz_q    <= dbz_d;
      op1_q    <= op1_d;
      b_q      <= b_d;
      res_q    <= res_d;
      res_hi_q <= res_hi_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      cnt_q    <= cnt_d;
    end
  end

  // Stall starts combinationally in the cycle Start is presented
  assign bus.Busy      = ((state_q == S_IDLE) && bus.Start) || (state_q == S_COMPUTE) ||
                         (state_q == S_FIXUP);
  assign bus.Done      = (state_q == S_DONE);
  assign bus.Result    = res_q;
  assign bus.ResultHi  = res_hi_q;
  assign bus.DivByZero = dbz_q;
endmodule

// File: tb/tb_mcycle_muldiv.sv
// Scoreboard bench for mcycle_muldiv: directed ops queued with expected results, checked on Done.
module tb_mcycle_muldiv;
  localparam int unsigned WIDTH = 32;
`ifdef MCYCLE_EARLY_OUT_EN
  localparam bit EO = 1'b1;
`else
  localparam bit EO = 1'b0;
`endif

  typedef struct {
    logic [31:0] res;
    logic [31:0] hi;
    logic        dbz;
  } exp_t;

  logic  clk = 1'b0;
  logic  rst;
  int    n_cmp = 0;
  int    n_err = 0;
  int    cyc   = 0;
  int    last_done_cyc = 0;
  exp_t  sb[$];
  string nm[$];

  mcycle_muldiv_if #(.WIDTH(WIDTH)) bus ();
  mcycle_muldiv #(.WIDTH(WIDTH)) dut (.CLK(clk), .Reset(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: pop the expected response whenever Done is presented
  always @(negedge clk) begin
    if (!rst && bus.Done === 1'b1) begin
      last_done_cyc = cyc;
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got Done with empty scoreboard, expected none");
      end else begin
        exp_t  e;
        string n;
        e = sb.pop_front();
        n = nm.pop_front();
        check({n, ".Result"},    64'(bus.Result),    64'(e.res));
        check({n, ".ResultHi"},  64'(bus.ResultHi),  64'(e.hi));
        check({n, ".DivByZero"}, 64'(bus.DivByZero), 64'(e.dbz));
      end
    end
  end

  task automatic push_exp(string name, logic [31:0] er, logic [31:0] eh, logic ed);
    exp_t e;
    e.res = er; e.hi = eh; e.dbz = ed;
    sb.push_back(e);
    nm.push_back(name);
  endtask

  // Wait (bounded) until Done; returns at negedge+1 of the DONE cycle
  task automatic wait_done(string name, output bit seen);
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      #1;
      if (bus.Done) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s.timeout: got no Done, expected Done within 200 cycles", name);
    end
  endtask

  task automatic run_op(string name, logic [1:0] op, logic [31:0] a, logic [31:0] b,
                        logic [31:0] er, logic [31:0] eh, logic ed, int eb);
    int busy;
    bit seen;
    push_exp(name, er, eh, ed);
    @(negedge clk);
    bus.Start = 1'b1; bus.MCycleOp = op; bus.Operand1 = a; bus.Operand2 = b;
    busy = 0;
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      #1;
      if (bus.Busy) busy++;
      if (bus.Done) seen = 1'b1;
      else begin
        @(negedge clk);
        bus.Start = 1'b0;
      end
    end
    if (!seen) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s.timeout: got no Done, expected Done within 200 cycles", name);
    end
    check({name, ".busy_cycles"}, 64'(busy), 64'(eb));
    @(negedge clk);
    #1;
    check({name, ".done_pulse"}, 64'(bus.Done), 64'(0));
  endtask

  initial begin
    bit seen;
    int t1;
    rst = 1'b1;
    bus.Start = 1'b0; bus.MCycleOp = 2'b00; bus.Operand1 = '0; bus.Operand2 = '0;
    repeat (3) @(negedge clk);
    check("reset.Busy",      64'(bus.Busy),      64'(0));
    check("reset.Done",      64'(bus.Done),      64'(0));
    check("reset.DivByZero", 64'(bus.DivByZero), 64'(0));
    check("reset.Result",    64'(bus.Result),    64'(0));
    check("reset.ResultHi",  64'(bus.ResultHi),  64'(0));
    rst = 1'b0;

    run_op("umul_max",  2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0, 34);
    run_op("smul_m3x7", 2'b01, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFEB, 32'hFFFFFFFF, 1'b0, EO ? 5 : 34);
    run_op("smul_m4xm5",2'b01, 32'hFFFFFFFC, 32'hFFFFFFFB, 32'd20,       32'd0,        1'b0, EO ? 5 : 34);
    run_op("smul_minxm1",2'b01,32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0, EO ? 3 : 34);
    run_op("umul_x0",   2'b00, 32'd9,        32'd0,        32'd0,        32'd0,        1'b0, EO ? 3 : 34);
    run_op("sdiv_m7d2", 2'b11, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 34);
    run_op("sdiv_7dm2", 2'b11, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        1'b0, 34);
    run_op("udiv_100d7",2'b10, 32'd100,      32'd7,        32'd14,       32'd2,        1'b0, 34);
    run_op("udiv_3d10", 2'b10, 32'd3,        32'd10,       32'd0,        32'd3,        1'b0, 34);
    run_op("div_zero",  2'b11, 32'h00001234, 32'd0,        32'hFFFFFFFF, 32'h00001234, 1'b1, 34);
    run_op("sdiv_minm1",2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0, 34);
    run_op("umul_5x3",  2'b00, 32'd5,        32'd3,        32'd15,       32'd0,        1'b0, EO ? 4 : 34);

    // Start held through DONE, then a second op presented in the following IDLE cycle
    push_exp("hold_first",  32'd14, 32'd2, 1'b0);
    push_exp("hold_second", 32'd10, 32'd0, 1'b0);
    @(negedge clk);
    bus.Start = 1'b1; bus.MCycleOp = 2'b10; bus.Operand1 = 32'd100; bus.Operand2 = 32'd7;
    wait_done("hold_first", seen);
    check("hold.busy_in_done", 64'(bus.Busy), 64'(0));
    t1 = last_done_cyc;
    @(negedge clk);
    bus.Operand1 = 32'd50; bus.Operand2 = 32'd5;
    #1;
    check("hold.busy_accept", 64'(bus.Busy), 64'(1));
    @(negedge clk);
    bus.Start = 1'b0;
    wait_done("hold_second", seen);
    check("hold.done_spacing", 64'(last_done_cyc - t1), 64'(35));
    @(negedge clk);

    // Reset during COMPUTE cycle 10 discards the op and clears the outputs
    @(negedge clk);
    bus.Start = 1'b1; bus.MCycleOp = 2'b10; bus.Operand1 = 32'd100; bus.Operand2 = 32'd7;
    @(negedge clk);
    bus.Start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("midreset.Busy",      64'(bus.Busy),      64'(0));
    check("midreset.Done",      64'(bus.Done),      64'(0));
    check("midreset.Result",    64'(bus.Result),    64'(0));
    check("midreset.ResultHi",  64'(bus.ResultHi),  64'(0));
    check("midreset.DivByZero", 64'(bus.DivByZero), 64'(0));
    rst = 1'b0;
    run_op("post_reset_6x7", 2'b00, 32'd6, 32'd7, 32'd42, 32'd0, 1'b0, EO ? 5 : 34);

    repeat (40) @(negedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
